alarm_mode_ctrl: RTL and testbench
==================================

// Module: alarm_mode_ctrl
// PURPOSE
//   Mode sequencer directly upstream of the LED/buzzer pattern driver. Produces its mode[1:0] code
//   (00 off, 01 welcome, 11 alarm) from UART command bytes and a debounced intrusion sensor.
//   Owns the arm/disarm, entry-delay and alarm-timeout policy. Contains no pattern generation.
// PARAMETERS
//   CLK_HZ        50_000_000  clock frequency; the ms tick fires every CLK_HZ/1000 cycles
//   WELCOME_MS    3000        WELCOME dwell time before automatic return to IDLE
//   ENTRY_MS      5000        grace time in ENTRY before ALARM
//   ALARM_MAX_MS  60000       ALARM duration before automatic fall-back to ARMED
//   DEBOUNCE_MS   20          sensor level must be stable this many ticks to be accepted
// PORTS
//   clk        in   1  system clock (50 MHz)
//   rst        in   1  synchronous reset, active-high
//   cmd_valid  in   1  one-cycle strobe: cmd_data holds a received byte
//   cmd_data   in   8  command byte: 0x57 'W' welcome, 0x41 'A' arm, 0x44 'D' disarm
//   sensor_in  in   1  raw intrusion sensor, asynchronous, active-high
//   mode       out  2  pattern code to the LED/buzzer driver
//   armed      out  1  high in ARMED, ENTRY, ALARM
//   state_out  out  3  IDLE=0 WELCOME=1 ARMED=2 ENTRY=3 ALARM=4
//   cmd_err    out  1  one-cycle pulse: unrecognised byte
// BEHAVIOUR
//   Reset:
//   - rst high at an edge forces state IDLE, mode 00, armed 0, cmd_err 0.
//   - Reset clears the timer, prescaler, debounce counter and synchronisers.
//   - rst overrides every other input and applies mid-operation, including in ALARM.
//   Tick and timer:
//   - ms_tick is a 1-cycle pulse from a free-running prescaler (width $clog2(CLK_HZ/1000)).
//   - The state timer is 17 bits. It clears on every state entry, including a re-entry, and
//     increments on each ms_tick.
//   - Timeout fires on the tick that brings the timer to X_MS. Elapsed time is in (X_MS-1, X_MS] ms.
//   Sensor:
//   - sensor_in passes through a 2-FF synchroniser.
//   - sensor_db copies the synchronised level after DEBOUNCE_MS consecutive ticks of a level
//     that differs from sensor_db. A glitch restarts the count.
//   - intrusion = 1-cycle pulse on the rising edge of sensor_db.
//   State transitions:
//   - IDLE: mode 00. 'W' -> WELCOME. 'A' -> ARMED. 'D' and intrusion are ignored.
//   - WELCOME: mode 01. Timeout -> IDLE. 'W' restarts the timer. 'A' -> ARMED. 'D' -> IDLE.
//   - ARMED: mode 00, armed 1. Intrusion -> ENTRY. 'D' -> IDLE. 'W' and 'A' are ignored.
//   - ENTRY: mode 01, armed 1. 'D' -> IDLE. Timeout -> ALARM. Other commands are ignored.
//   - ALARM: mode 11, armed 1. 'D' -> IDLE. Timeout -> ARMED. Other commands and intrusion are ignored.
//   Latency and outputs:
//   - mode, armed and state_out are registered and decoded from the next state.
//   - They change on the same edge that samples cmd_valid or the timeout/intrusion pulse.
//   - They are visible 1 cycle after the triggering cycle.
//   Command handling:
//   - No back-pressure: every cmd_valid is consumed in its own cycle.
//   - A recognised code that does not apply in the current state is ignored and raises no error.
//   - A byte other than 0x57/0x41/0x44 pulses cmd_err for exactly 1 cycle and leaves the state
//     unchanged. Lower-case bytes are errors.
//   Simultaneous events:
//   - A command beats a timeout or intrusion in the same cycle. 'D' + ENTRY timeout -> IDLE.
//     'D' + intrusion in ARMED -> IDLE.
//   - 'W' in WELCOME on the timeout cycle restarts the dwell.
//   - Illegal state encodings recover to IDLE.
// STRUCTURE
//   Shared package alarm_pkg:
//   - MODE_OFF=2'b00, MODE_WELCOME=2'b01, MODE_ALARM=2'b11
//   - state localparams (IDLE..ALARM)
//   - CMD_WELCOME/CMD_ARM/CMD_DISARM byte constants
//   Sub-module ms_tick_gen (CLK_HZ): prescaler producing ms_tick; also reused by other timed blocks.
//   Synchroniser, debouncer, FSM and timer stay in this module.
// TESTING (bench: CLK_HZ=10_000 -> tick every 10 clk; WELCOME_MS=5, ENTRY_MS=4, ALARM_MAX_MS=6,
//   DEBOUNCE_MS=2)
//   1. rst 2 cycles, then 'W' -> next cycle mode=01, state_out=1. After 5 ticks -> mode=00, state_out=0.
//   2. 'A'; sensor high 12 clk -> still ARMED, mode=00. Sensor high 40 clk -> ENTRY, mode=01,
//      armed=1. Then 'D' -> IDLE, armed=0.
//   3. 'A', hold sensor: ENTRY. After 4 ticks -> ALARM, mode=11. After 6 more ticks -> ARMED,
//      mode=00, armed=1.
//   4. cmd_data=0x58 -> cmd_err high exactly 1 cycle, state unchanged. 'W' while ARMED -> no change,
//      cmd_err=0.
//   5. In ENTRY, assert 'D' on the timeout tick cycle -> IDLE, never ALARM. rst high in ALARM ->
//      mode=00, state_out=0 next cycle.
//   6. 'W', then 'W' again at tick 4 -> mode stays 01 for a further 5 ticks.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared constants for the alarm mode sequencer: pattern codes, state encodings, command bytes.
package alarm_pkg;

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_WELCOME = 2'b01;
  localparam logic [1:0] MODE_ALARM   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WELCOME = 3'd1,
    ST_ARMED   = 3'd2,
    ST_ENTRY   = 3'd3,
    ST_ALARM   = 3'd4
  } state_t;

  localparam logic [7:0] CMD_WELCOME = 8'h57;
  localparam logic [7:0] CMD_ARM     = 8'h41;
  localparam logic [7:0] CMD_DISARM  = 8'h44;

  function automatic logic [1:0] mode_of(state_t s);
    case (s)
      ST_WELCOME, ST_ENTRY: mode_of = MODE_WELCOME;
      ST_ALARM:             mode_of = MODE_ALARM;
      default:              mode_of = MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running prescaler: one-cycle ms_tick every CLK_HZ/1000 clocks.
module ms_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic ms_tick
);

  localparam int DIV = CLK_HZ / 1000;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign ms_tick = (cnt == LAST);

endmodule

// File: rtl/alarm_mode_ctrl.sv
// Arm/disarm, entry-delay and alarm-timeout sequencer feeding the LED/buzzer pattern driver.
module alarm_mode_ctrl
  import alarm_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int WELCOME_MS   = 3000,
  parameter int ENTRY_MS     = 5000,
  parameter int ALARM_MAX_MS = 60000,
  parameter int DEBOUNCE_MS  = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  input  logic       sensor_in,
  output logic [1:0] mode,
  output logic       armed,
  output logic [2:0] state_out,
  output logic       cmd_err
);

  localparam int DBW = $clog2(DEBOUNCE_MS + 1);

  logic           ms_tick;
  logic           s_meta, s_sync, sensor_db, sensor_db_q, intrusion;
  logic [DBW-1:0] db_cnt;
  logic [16:0]    timer, limit;
  logic           tmo, timer_clr, restart;
  logic           is_w, is_a, is_d, cmd_bad;
  state_t         state, nxt;

  ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (.clk(clk), .rst(rst), .ms_tick(ms_tick));

  // Debounce counts ticks only while the synchronised level disagrees with the accepted one.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_meta      <= 1'b0;
      s_sync      <= 1'b0;
      sensor_db   <= 1'b0;
      sensor_db_q <= 1'b0;
      db_cnt      <= '0;
    end else begin
      s_meta      <= sensor_in;
      s_sync      <= s_meta;
      sensor_db_q <= sensor_db;
      if (s_sync == sensor_db) begin
        db_cnt <= '0;
      end else if (ms_tick) begin
        if (db_cnt == DBW'(DEBOUNCE_MS - 1)) begin
          sensor_db <= s_sync;
          db_cnt    <= '0;
        end else begin
          db_cnt <= db_cnt + DBW'(1);
        end
      end
    end
  end

  assign intrusion = sensor_db & ~sensor_db_q;

  assign is_w    = cmd_valid && (cmd_data == CMD_WELCOME);
  assign is_a    = cmd_valid && (cmd_data == CMD_ARM);
  assign is_d    = cmd_valid && (cmd_data == CMD_DISARM);
  assign cmd_bad = cmd_valid && !(is_w || is_a || is_d);

  always_comb begin
    limit = '0;
    case (state)
      ST_WELCOME: limit = 17'(WELCOME_MS);
      ST_ENTRY:   limit = 17'(ENTRY_MS);
      ST_ALARM:   limit = 17'(ALARM_MAX_MS);
      default:    limit = '0;
    endcase
  end

  assign tmo = ms_tick && (limit != '0) && (timer == limit - 17'd1);

  // Commands are checked before timeout/intrusion so they win on a shared cycle.
  always_comb begin
    nxt     = state;
    restart = 1'b0;
    case (state)
      ST_IDLE: begin
        if (is_w)      nxt = ST_WELCOME;
        else if (is_a) nxt = ST_ARMED;
      end
      ST_WELCOME: begin
        if (is_w)      restart = 1'b1;
        else if (is_a) nxt = ST_ARMED;
        else if (is_d) nxt = ST_IDLE;
        else if (tmo)  nxt = ST_IDLE;
      end
      ST_ARMED: begin
        if (is_d)           nxt = ST_IDLE;
        else if (intrusion) nxt = ST_ENTRY;
      end
      ST_ENTRY: begin
        if (is_d)     nxt = ST_IDLE;
        else if (tmo) nxt = ST_ALARM;
      end
      ST_ALARM: begin
        if (is_d)     nxt = ST_IDLE;
        else if (tmo) nxt = ST_ARMED;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  assign timer_clr = restart || (nxt != state);

  always_ff @(posedge clk) begin
    if (rst)                           timer <= '0;
    else if (timer_clr)                timer <= '0;
    else if (ms_tick && timer != '1)   timer <= timer + 17'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      mode    <= MODE_OFF;
      armed   <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      state   <= nxt;
      mode    <= mode_of(nxt);
      armed   <= (nxt == ST_ARMED) || (nxt == ST_ENTRY) || (nxt == ST_ALARM);
      cmd_err <= cmd_bad;
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_alarm_mode_ctrl.sv
// Directed bench for alarm_mode_ctrl with a 10-clock ms tick; expectations go through a scoreboard queue.
module tb_alarm_mode_ctrl;
  import alarm_pkg::*;

  logic       clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, sensor_in = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic [1:0] mode;
  logic       armed, cmd_err;
  logic [2:0] state_out;

  int n_cmp = 0, n_bad = 0, cyc = 0;

  typedef struct {
    string      tag;
    logic [6:0] exp;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  alarm_mode_ctrl #(
    .CLK_HZ(10_000), .WELCOME_MS(5), .ENTRY_MS(4), .ALARM_MAX_MS(6), .DEBOUNCE_MS(2)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data), .sensor_in(sensor_in),
    .mode(mode), .armed(armed), .state_out(state_out), .cmd_err(cmd_err)
  );

  // cyc counts edges since the last reset edge; ticks are sampled on edges where cyc%10==0.
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic send(input logic [7:0] b);
    cmd_valid = 1'b1;
    cmd_data  = b;
    step();
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      while (cyc % 10 != 0) step();
    end
  endtask

  task automatic pre_tick();
    while (cyc % 10 != 9) step();
  endtask

  task automatic expect_out(input string tag, input logic [2:0] st, input logic [1:0] md,
                            input logic ar, input logic er);
    exp_t e;
    e.tag = tag;
    e.exp = {st, md, ar, er};
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t       e;
    logic [6:0] obs;
    e   = sb.pop_front();
    obs = {state_out, mode, armed, cmd_err};
    n_cmp++;
    assert (obs === e.exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed st=%0d mode=%b armed=%b err=%b, expected st=%0d mode=%b armed=%b err=%b",
             e.tag, obs[6:4], obs[3:2], obs[1], obs[0], e.exp[6:4], e.exp[3:2], e.exp[1], e.exp[0]);
    end
  endtask

  task automatic chk(input string tag, input logic [2:0] st, input logic [1:0] md,
                     input logic ar, input logic er);
    expect_out(tag, st, md, ar, er);
    compare();
  endtask

  // Bounded wait; an expired bound shows up as a failed comparison in the caller's chk.
  task automatic wait_state(input logic [2:0] st, input int bound);
    for (int i = 0; i < bound; i++) begin
      step();
      if (state_out === st) break;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset and welcome dwell
    do_reset(2);
    chk("reset", 3'd0, 2'b00, 1'b0, 1'b0);
    send(CMD_WELCOME);
    chk("welcome", 3'd1, 2'b01, 1'b0, 1'b0);
    ticks(4);
    chk("welcome_t4", 3'd1, 2'b01, 1'b0, 1'b0);
    ticks(1);
    chk("welcome_tmo", 3'd0, 2'b00, 1'b0, 1'b0);
    send(CMD_DISARM);
    chk("idle_d_ignored", 3'd0, 2'b00, 1'b0, 1'b0);
    send(8'h61);
    chk("lowercase_err", 3'd0, 2'b00, 1'b0, 1'b1);

    // 2: debounce rejects a short assertion, accepts a long one
    send(CMD_ARM);
    chk("arm", 3'd2, 2'b00, 1'b1, 1'b0);
    sensor_in = 1'b1;
    repeat (12) step();
    chk("sensor_12clk", 3'd2, 2'b00, 1'b1, 1'b0);
    repeat (28) step();
    chk("sensor_40clk", 3'd3, 2'b01, 1'b1, 1'b0);
    send(CMD_DISARM);
    chk("entry_disarm", 3'd0, 2'b00, 1'b0, 1'b0);

    // 3: entry -> alarm -> armed
    sensor_in = 1'b0;
    repeat (40) step();
    send(CMD_ARM);
    chk("arm2", 3'd2, 2'b00, 1'b1, 1'b0);
    sensor_in = 1'b1;
    wait_state(3'd3, 60);
    chk("entry2", 3'd3, 2'b01, 1'b1, 1'b0);
    ticks(3);
    chk("entry_t3", 3'd3, 2'b01, 1'b1, 1'b0);
    ticks(1);
    chk("alarm", 3'd4, 2'b11, 1'b1, 1'b0);
    ticks(5);
    chk("alarm_t5", 3'd4, 2'b11, 1'b1, 1'b0);
    ticks(1);
    chk("alarm_tmo", 3'd2, 2'b00, 1'b1, 1'b0);

    // 4: bad byte and ignored commands
    send(8'h58);
    chk("err_pulse", 3'd2, 2'b00, 1'b1, 1'b1);
    step();
    chk("err_clear", 3'd2, 2'b00, 1'b1, 1'b0);
    send(CMD_WELCOME);
    chk("armed_w_ignored", 3'd2, 2'b00, 1'b1, 1'b0);
    send(CMD_ARM);
    chk("armed_a_ignored", 3'd2, 2'b00, 1'b1, 1'b0);

    // 5: disarm on the entry timeout tick, then reset out of alarm
    sensor_in = 1'b0;
    repeat (40) step();
    sensor_in = 1'b1;
    wait_state(3'd3, 60);
    chk("entry3", 3'd3, 2'b01, 1'b1, 1'b0);
    ticks(3);
    pre_tick();
    send(CMD_DISARM);
    chk("disarm_on_tmo", 3'd0, 2'b00, 1'b0, 1'b0);
    repeat (15) step();
    chk("never_alarm", 3'd0, 2'b00, 1'b0, 1'b0);
    send(CMD_ARM);
    chk("arm3", 3'd2, 2'b00, 1'b1, 1'b0);
    sensor_in = 1'b0;
    repeat (40) step();
    sensor_in = 1'b1;
    wait_state(3'd3, 60);
    chk("entry4", 3'd3, 2'b01, 1'b1, 1'b0);
    ticks(4);
    chk("alarm2", 3'd4, 2'b11, 1'b1, 1'b0);
    do_reset(1);
    chk("rst_in_alarm", 3'd0, 2'b00, 1'b0, 1'b0);
    sensor_in = 1'b0;

    // 6: welcome restarts, including on the timeout tick
    send(CMD_WELCOME);
    chk("welcome2", 3'd1, 2'b01, 1'b0, 1'b0);
    ticks(3);
    pre_tick();
    send(CMD_WELCOME);
    chk("w_at_tick4", 3'd1, 2'b01, 1'b0, 1'b0);
    ticks(4);
    chk("restart_t4", 3'd1, 2'b01, 1'b0, 1'b0);
    pre_tick();
    send(CMD_WELCOME);
    chk("w_on_tmo", 3'd1, 2'b01, 1'b0, 1'b0);
    ticks(4);
    chk("restart2_t4", 3'd1, 2'b01, 1'b0, 1'b0);
    ticks(1);
    chk("restart2_tmo", 3'd0, 2'b00, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
